// File: rtl/sprite_mover.sv
// sprite_mover: frame-rate sprite that patrols a rectangle and yields to keys.
// Define SPRITE_MOVER_TIMEOUT_EN to return from MANUAL after TIMEOUT idle frames.
module sprite_mover #(
   parameter int X_CENTER = 320,
   parameter int Y_CENTER = 240,
   parameter int X_LO     = 270,
   parameter int X_HI     = 370,
   parameter int Y_LO     = 190,
   parameter int Y_HI     = 290,
   parameter int STEP     = 1,
   parameter int SIZE     = 8,
   parameter int TIMEOUT  = 60
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       Run,
   input  logic [7:0] keycode,
   output logic [9:0] BallX,
   output logic [9:0] BallY,
   output logic [9:0] BallS,
   output logic [2:0] State
);

   typedef enum logic [2:0] {
      ST_RETURN = 3'd0,
      ST_TOP    = 3'd1,
      ST_LEFT   = 3'd2,
      ST_BOTTOM = 3'd3,
      ST_RIGHT  = 3'd4,
      ST_MANUAL = 3'd5
   } state_t;

   localparam logic [10:0] STEP11 = 11'(STEP);
   localparam logic [9:0]  XC     = 10'(X_CENTER);
   localparam logic [9:0]  YC     = 10'(Y_CENTER);
   localparam logic [9:0]  XL     = 10'(X_LO);
   localparam logic [9:0]  XH     = 10'(X_HI);
   localparam logic [9:0]  YL     = 10'(Y_LO);
   localparam logic [9:0]  YH     = 10'(Y_HI);
   localparam logic [9:0]  XMIN   = 10'(SIZE);
   localparam logic [9:0]  XMAX   = 10'(639 - SIZE);
   localparam logic [9:0]  YMIN   = 10'(SIZE);
   localparam logic [9:0]  YMAX   = 10'(479 - SIZE);

   state_t     state_q, state_d;
   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic [9:0] man_x, man_y;
   logic       key_vld;

`ifdef SPRITE_MOVER_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   logic [TW-1:0] timer_q, timer_d;
`else
   localparam int unused_timeout = TIMEOUT;
`endif

   // min(v + STEP, lim), widened so the sum cannot wrap
   function automatic logic [9:0] inc_to(input logic [9:0] v,
                                         input logic [9:0] lim);
      logic [10:0] s;
      s = {1'b0, v} + STEP11;
      return (s > {1'b0, lim}) ? lim : s[9:0];
   endfunction

   // max(v - STEP, lim), guarded so the difference cannot underflow
   function automatic logic [9:0] dec_to(input logic [9:0] v,
                                         input logic [9:0] lim);
      logic [10:0] d;
      d = {1'b0, v} - STEP11;
      return ({1'b0, v} < ({1'b0, lim} + STEP11)) ? lim : d[9:0];
   endfunction

   // decode the keycode into a clamped manual move
   always_comb begin
      man_x   = x_q;
      man_y   = y_q;
      key_vld = 1'b1;
      unique case (1'b1)
         (keycode == 8'h04): man_x = dec_to(x_q, XMIN);
         (keycode == 8'h07): man_x = inc_to(x_q, XMAX);
         (keycode == 8'h16): man_y = inc_to(y_q, YMAX);
         (keycode == 8'h1A): man_y = dec_to(y_q, YMIN);
         default:            key_vld = 1'b0;
      endcase
   end

   // next position and state from this edge's inputs
   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      state_d = state_q;
`ifdef SPRITE_MOVER_TIMEOUT_EN
      timer_d = timer_q;
`endif
      if (Run) begin
         if (key_vld) begin
            x_d     = man_x;
            y_d     = man_y;
            state_d = ST_MANUAL;
`ifdef SPRITE_MOVER_TIMEOUT_EN
            timer_d = '0;
`endif
         end else begin
            unique case (state_q)
               ST_RETURN: begin
                  if (x_q != XH)
                     x_d = (x_q < XH) ? inc_to(x_q, XH)
                                      : dec_to(x_q, XH);
                  else if (y_q != YL)
                     y_d = (y_q < YL) ? inc_to(y_q, YL)
                                      : dec_to(y_q, YL);
                  if (x_d == XH && y_d == YL)
                     state_d = ST_TOP;
               end
               ST_TOP: begin
                  x_d = dec_to(x_q, XL);
                  if (x_d == XL) state_d = ST_LEFT;
               end
               ST_LEFT: begin
                  y_d = inc_to(y_q, YH);
                  if (y_d == YH) state_d = ST_BOTTOM;
               end
               ST_BOTTOM: begin
                  x_d = inc_to(x_q, XH);
                  if (x_d == XH) state_d = ST_RIGHT;
               end
               ST_RIGHT: begin
                  y_d = dec_to(y_q, YL);
                  if (y_d == YL) state_d = ST_TOP;
               end
               ST_MANUAL: begin
`ifdef SPRITE_MOVER_TIMEOUT_EN
                  if (timer_q == T_LAST) begin
                     state_d = ST_RETURN;
                     timer_d = '0;
                  end else begin
                     timer_d = timer_q + 1'b1;
                  end
`endif
               end
               default: state_d = ST_RETURN;
            endcase
         end
      end
   end

   // state registers; reset recentres the sprite without a clock
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         x_q     <= XC;
         y_q     <= YC;
         state_q <= ST_RETURN;
`ifdef SPRITE_MOVER_TIMEOUT_EN
         timer_q <= '0;
`endif
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         state_q <= state_d;
`ifdef SPRITE_MOVER_TIMEOUT_EN
         timer_q <= timer_d;
`endif
      end
   end

   assign BallX = x_q;
   assign BallY = y_q;
   assign BallS = 10'(SIZE);
   assign State = state_q;

endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: directed and random checks of sprite_mover.
// Reference model uses plain integer min/max rules for each state.
module tb_sprite_mover;
   localparam int XC  = 320;
   localparam int YC  = 240;
   localparam int XLO = 270;
   localparam int XHI = 370;
   localparam int YLO = 190;
   localparam int YHI = 290;
   localparam int STP = 1;
   localparam int SZ  = 8;
   localparam int TO  = 60;

   logic       frame_clk = 1'b0;
   logic       Reset;
   logic       Run;
   logic [7:0] keycode;
   logic [9:0] BallX, BallY, BallS;
   logic [2:0] State;

   int checks = 0;
   int errors = 0;
   int mx, my, ms, mt;
   logic [7:0] keys [4] = '{8'h04, 8'h07, 8'h16, 8'h1A};

   always #5 frame_clk = ~frame_clk;

   sprite_mover #(
      .X_CENTER(XC), .Y_CENTER(YC),
      .X_LO(XLO), .X_HI(XHI),
      .Y_LO(YLO), .Y_HI(YHI),
      .STEP(STP), .SIZE(SZ), .TIMEOUT(TO)
   ) dut (
      .frame_clk(frame_clk),
      .Reset(Reset),
      .Run(Run),
      .keycode(keycode),
      .BallX(BallX),
      .BallY(BallY),
      .BallS(BallS),
      .State(State)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic m_reset();
      mx = XC; my = YC; ms = 0; mt = 0;
   endtask

   // one enabled frame of the behavioural sprite
   task automatic m_edge(input bit run, input logic [7:0] key);
      if (!run) return;
      if (key == 8'h04 || key == 8'h07 ||
          key == 8'h16 || key == 8'h1A) begin
         ms = 5; mt = 0;
         if (key == 8'h04) mx = imax(mx - STP, SZ);
         if (key == 8'h07) mx = imin(mx + STP, 639 - SZ);
         if (key == 8'h16) my = imin(my + STP, 479 - SZ);
         if (key == 8'h1A) my = imax(my - STP, SZ);
         return;
      end
      case (ms)
         0: begin
            if (mx < XHI) mx = imin(mx + STP, XHI);
            else if (mx > XHI) mx = imax(mx - STP, XHI);
            else if (my < YLO) my = imin(my + STP, YLO);
            else if (my > YLO) my = imax(my - STP, YLO);
            if (mx == XHI && my == YLO) ms = 1;
         end
         1: begin mx = imax(mx - STP, XLO); if (mx == XLO) ms = 2; end
         2: begin my = imin(my + STP, YHI); if (my == YHI) ms = 3; end
         3: begin mx = imin(mx + STP, XHI); if (mx == XHI) ms = 4; end
         4: begin my = imax(my - STP, YLO); if (my == YLO) ms = 1; end
         default: begin
`ifdef SPRITE_MOVER_TIMEOUT_EN
            mt++;
            if (mt == TO) begin ms = 0; mt = 0; end
`endif
         end
      endcase
   endtask

   task automatic cmp(input string tag);
      chk({tag, "_x"}, int'(BallX), mx);
      chk({tag, "_y"}, int'(BallY), my);
      chk({tag, "_st"}, int'(State), ms);
   endtask

   // drive one frame, then sample 1 time unit after the edge
   task automatic tick(input bit run, input logic [7:0] key);
      Run = run;
      keycode = key;
      @(posedge frame_clk);
      #1;
      m_edge(run, key);
      cmp("edge");
   endtask

   // asynchronous reset pulse placed between clock edges
   task automatic pulse_reset();
      Run = 1'b1;
      keycode = 8'h07;
      Reset = 1'b1;
      #1;
      m_reset();
      cmp("rst");
      chk("rst_s", int'(BallS), SZ);
      Reset = 1'b0;
   endtask

   initial begin
      int kp, r;
      logic [7:0] k;
      Reset = 1'b1;
      Run = 1'b0;
      keycode = 8'h00;
      #2;
      chk("por_x", int'(BallX), XC);
      chk("por_y", int'(BallY), YC);
      chk("por_st", int'(State), 0);
      chk("por_s", int'(BallS), SZ);
      @(posedge frame_clk);
      #1;
      Reset = 1'b0;
      m_reset();

      // reset release into the patrol loop
      for (int e = 1; e <= 500; e++) begin
         tick(1'b1, 8'h00);
         if (e == 50) begin
            chk("e50_x", int'(BallX), 370);
            chk("e50_y", int'(BallY), 240);
         end
         if (e == 100) begin
            chk("e100_y", int'(BallY), 190);
            chk("e100_st", int'(State), 1);
         end
         if (e == 101) chk("e101_x", int'(BallX), 369);
         if (e == 200) begin
            chk("e200_x", int'(BallX), 270);
            chk("e200_st", int'(State), 2);
         end
         if (e == 300) begin
            chk("e300_y", int'(BallY), 290);
            chk("e300_st", int'(State), 3);
         end
         if (e == 400) chk("e400_st", int'(State), 4);
         if (e == 500) begin
            chk("e500_x", int'(BallX), 370);
            chk("e500_y", int'(BallY), 190);
            chk("e500_st", int'(State), 1);
         end
      end

      // freeze mid-patrol
      for (int i = 0; i < 30; i++) tick(1'b1, 8'h00);
      for (int i = 0; i < 10; i++) tick(1'b0, 8'h00);
      chk("hold_x", int'(BallX), 340);
      chk("hold_y", int'(BallY), 190);
      chk("hold_st", int'(State), 1);
      for (int i = 0; i < 40; i++) tick(1'b1, 8'h00);
      chk("at300_x", int'(BallX), 300);

      // S key takes over from TOP
      for (int i = 1; i <= 3; i++) begin
         tick(1'b1, 8'h16);
         chk("s_st", int'(State), 5);
         chk("s_x", int'(BallX), 300);
         chk("s_y", int'(BallY), 190 + i);
      end

      // saturate at the left and top edges
      for (int i = 0; i < 297; i++) tick(1'b1, 8'h04);
      chk("clampL_x", int'(BallX), 8);
      for (int i = 0; i < 190; i++) tick(1'b1, 8'h1A);
      chk("clampT_y", int'(BallY), 8);
      chk("clampT_x", int'(BallX), 8);

`ifdef SPRITE_MOVER_TIMEOUT_EN
      for (int i = 1; i <= 58; i++) tick(1'b1, 8'h00);
      tick(1'b1, 8'h1A);
      for (int i = 1; i <= 60; i++) begin
         tick(1'b1, 8'h00);
         chk("to_st", int'(State), (i < 60) ? 5 : 0);
      end
`else
      for (int i = 1; i <= 100; i++) begin
         tick(1'b1, 8'h00);
         chk("man_st", int'(State), 5);
      end
      chk("man_x", int'(BallX), 8);
`endif

      pulse_reset();
      tick(1'b1, 8'h00);
      chk("post_x", int'(BallX), 321);

      // random traffic in bursts of key-heavy and idle frames
      for (int b = 0; b < 20; b++) begin
         kp = ($urandom_range(0, 1) != 0) ? 10 : 0;
         for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < kp) k = keys[$urandom_range(0, 3)];
            else if (r < kp + 3) k = 8'($urandom_range(0, 255));
            else k = 8'h00;
            tick($urandom_range(0, 9) != 0, k);
            if ($urandom_range(0, 299) == 0) pulse_reset();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
